bpu_btb_ras: RTL and testbench
==============================

# bpu_btb_ras

Parametrised branch target buffer with an integrated circular return-address stack, used by the IF stage for next-PC prediction and updated from ID/EX. It generalises the previous fixed 32-entry BTB. Entry count, counter width and RAS depth are configurable, and each entry carries a branch kind. The RAS overwrites its oldest entry on overflow and supports checkpoint/restore for mispredict repair.

## Interface
- `BTB_ENTRIES`, 32: BTB entries; power of 2, 4..256.
- `RAS_DEPTH`, 8: RAS entries; power of 2, 2..64.
- `CNT_W`, 2: saturating counter width, 1..4.
- Derived: `IDX_W` = clog2(`BTB_ENTRIES`); `RP_W` = clog2(`RAS_DEPTH`).

Ports:
- `clk`  in  1  clock
- `reset`  in  1  sync, active-high
- `fetch_en`  in  1  lookup request
- `fetch_pc`  in  32  lookup PC
- `pred_valid`  out  1  BTB hit (or ret hit with non-empty RAS)
- `pred_taken`  out  1  predicted taken
- `pred_target`  out  32  predicted target, bits[1:0]=0
- `pred_index`  out  IDX_W  hit entry
- `pred_kind`  out  2  kind of hit entry
- `upd_en`  in  1  update strobe
- `upd_pc`  in  32  branch PC
- `upd_index`  in  IDX_W  entry from earlier prediction
- `upd_hit`  in  1  branch was predicted (index valid)
- `upd_kind`  in  2  branch kind
- `upd_taken`  in  1  resolved direction
- `upd_target`  in  32  resolved target
- `upd_tgt_err`  in  1  hit entry had wrong target
- `upd_delete`  in  1  invalidate `upd_index` (non-branch aliasing)
- `ras_push`, `ras_pop`  in  1 each  call/return committed at decode
- `ras_push_pc`  in  32  call PC
- `ras_ckpt`  out  RP_W+RP_W+1  {top ptr, count}
- `ras_restore_en`  in  1  restore strobe
- `ras_restore_ckpt`  in  RP_W+RP_W+1  checkpoint to restore
- `flush_all`  in  1  invalidate all BTB entries

## Operation
- Kinds (`bpu_pkg`): COND=0, JUMP=1, CALL=2, RET=3. Entry = valid, tag `pc[31:2]`, target `[31:2]`, counter, kind.
- Lookup: `fetch_pc`/`fetch_en` registered. Hit = registered enable & valid & tag match. On multiple matches the lowest index wins.
- `pred_taken`:
  - COND: counter MSB.
  - JUMP/CALL: 1.
  - RET: 1 only if RAS count ≠ 0, else the hit is suppressed (`pred_valid`=0).
- `pred_target`: RAS top for RET, else the stored target.
- When `pred_valid`=0, all pred outputs are 0.
- Update priority (one action per cycle): `flush_all` > `upd_delete` > allocate (`upd_hit`=0 and `upd_taken`=1) > `upd_tgt_err` > counter update (`upd_hit`=1).
- Allocate: writes tag, target, kind; counter = 2^(CNT_W-1). Victim choice:
  - lowest-index invalid entry;
  - else lowest-index valid entry with counter=0;
  - else LFSR[IDX_W-1:0].
- `upd_tgt_err`: rewrite target and kind; counter = 2^(CNT_W-1).
- Counter update: taken → saturating increment; not taken → saturating decrement.
- Not-taken miss: no BTB change.
- RAS is circular, holding `pc[31:2]`. Push writes `ras_push_pc[31:2]+1` at ptr+1 and advances ptr; count saturates at `RAS_DEPTH`, so on overflow the oldest entry is overwritten.
- Pop with count=0 is ignored. Otherwise pop does ptr−1 and count−1.
- Push and pop in the same cycle replace the top: write at ptr, ptr and count unchanged. If count=0, behave as a push.
- `ras_restore_en` loads ptr and count from `ras_restore_ckpt` and overrides push/pop in that cycle. Stack contents are not restored.
- LFSR: 8-bit Galois, taps x^8+x^6+x^5+x^4+1, seed 8'hA5, advances every cycle.

## Timing
- Reset: all valid bits 0, RAS ptr=0, count=0, LFSR=8'hA5, registered fetch enable 0. All pred outputs 0; `ras_ckpt`=0.
- Lookup latency is 1: fetch in cycle N, prediction in cycle N+1, combinational from the cycle N+1 array state.
- An update in cycle N+1 is not visible to the N+1 prediction. It is visible from N+2.
- RAS updates land at the clock edge. RET predictions in cycle N+1 see the RAS state at the start of N+1.
- `ras_ckpt` is the current state, combinational from registers.
- Reset mid-operation: everything is invalidated in one cycle. Array storage is not cleared.

## Structure
- `bpu_pkg`: kind enum, counter init function, checkpoint struct.
- Sub-module `prio_enc #(N)`: lowest-set-bit index plus any-flag. Used for hit select, invalid select and zero-counter select.
- LFSR stays inline.

## Test plan
- Reset then fetch 0x1000 → `pred_valid`=0. Allocate COND at 0x1000 → target 0x2000. Fetch 0x1000 → `pred_valid`=1, `pred_taken`=1, target 0x2000, `pred_index`=0.
- Three not-taken updates on index 0 (CNT_W=2) → counter 00, `pred_taken`=0. A fourth update keeps 00. Allocate into a full BTB → victim is index 0.
- Fill all 32 entries with counters ≥1, then allocate → victim = LFSR low 5 bits at that cycle (checked against model).
- Push calls at 0x100, 0x200, 0x300; RET entry hit → target 0x304. Pop, then ret → 0x204.
- Push RAS_DEPTH+1 calls → count=RAS_DEPTH and the oldest is overwritten. RAS_DEPTH+1 pops → the last pop is ignored and the RET hit is suppressed.
- Checkpoint after 2 pushes, push 2 more, restore → ret target = 2nd call PC+4. Restore with simultaneous push → push ignored.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared types for the branch predictor: branch kinds and the counter reset value.
package bpu_pkg;

  typedef enum logic [1:0] {
    KIND_COND = 2'd0,
    KIND_JUMP = 2'd1,
    KIND_CALL = 2'd2,
    KIND_RET  = 2'd3
  } kind_e;

  localparam int CNT_W_MAX = 4;

  // Weakly-taken starting point: only the counter MSB set.
  function automatic logic [CNT_W_MAX-1:0] cnt_init(input int cnt_w);
    return CNT_W_MAX'(1) << (cnt_w - 1);
  endfunction

endpackage

// File: rtl/bpu_btb_ras_prio_enc.sv
// Lowest-set-bit priority encoder with an any-bit-set flag.
module prio_enc #(
  parameter int N = 32,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scanning downward lets the lowest set index overwrite higher ones.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bpu_btb_ras.sv
// Branch target buffer with an integrated circular return-address stack for
// next-PC prediction in IF, trained from ID/EX.
module bpu_btb_ras
  import bpu_pkg::*;
#(
  parameter int BTB_ENTRIES = 32,
  parameter int RAS_DEPTH   = 8,
  parameter int CNT_W       = 2,
  localparam int IDX_W = $clog2(BTB_ENTRIES),
  localparam int RP_W  = $clog2(RAS_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_en,
  input  logic [31:0]         fetch_pc,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  output logic [IDX_W-1:0]    pred_index,
  output logic [1:0]          pred_kind,
  input  logic                upd_en,
  input  logic [31:0]         upd_pc,
  input  logic [IDX_W-1:0]    upd_index,
  input  logic                upd_hit,
  input  logic [1:0]          upd_kind,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target,
  input  logic                upd_tgt_err,
  input  logic                upd_delete,
  input  logic                ras_push,
  input  logic                ras_pop,
  input  logic [31:0]         ras_push_pc,
  output logic [2*RP_W:0]     ras_ckpt,
  input  logic                ras_restore_en,
  input  logic [2*RP_W:0]     ras_restore_ckpt,
  input  logic                flush_all
);

  typedef struct packed {
    logic [RP_W-1:0] ptr;
    logic [RP_W:0]   count;
  } ras_ckpt_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_init(CNT_W));
  localparam logic [RP_W:0]    RAS_FULL = (RP_W + 1)'(RAS_DEPTH);

  logic [BTB_ENTRIES-1:0] valid;
  logic [29:0]            tag_mem    [BTB_ENTRIES];
  logic [29:0]            target_mem [BTB_ENTRIES];
  logic [CNT_W-1:0]       cnt_mem    [BTB_ENTRIES];
  kind_e                  kind_mem   [BTB_ENTRIES];

  logic        fetch_en_q;
  logic [29:0] fetch_tag_q;

  logic [29:0]     ras_mem [RAS_DEPTH];
  logic [RP_W-1:0] ras_ptr, ras_ptr_nxt, ras_wptr;
  logic [RP_W:0]   ras_cnt, ras_cnt_nxt;
  logic            ras_we, ras_empty;
  ras_ckpt_t       restore_ckpt;

  logic [7:0] lfsr;

  logic [BTB_ENTRIES-1:0] hit_vec, zero_vec;
  logic [IDX_W-1:0]       hit_idx, inv_idx, zero_idx, victim;
  logic                   hit_any, inv_any, zero_any;
  kind_e                  hit_kind;
  logic do_delete, do_alloc, do_retarget, do_count;

  logic unused_bits;
  assign unused_bits = ^{fetch_pc[1:0], upd_pc[1:0], upd_target[1:0], ras_push_pc[1:0]};

  always_comb begin
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      hit_vec[i]  = fetch_en_q && valid[i] && (tag_mem[i] == fetch_tag_q);
      zero_vec[i] = valid[i] && (cnt_mem[i] == '0);
    end
  end

  prio_enc #(.N(BTB_ENTRIES)) u_hit  (.req(hit_vec),  .idx(hit_idx),  .any(hit_any));
  prio_enc #(.N(BTB_ENTRIES)) u_inv  (.req(~valid),   .idx(inv_idx),  .any(inv_any));
  prio_enc #(.N(BTB_ENTRIES)) u_zero (.req(zero_vec), .idx(zero_idx), .any(zero_any));

  assign ras_empty = (ras_cnt == '0);
  assign hit_kind  = kind_mem[hit_idx];

  // A return hit with nothing on the stack has no usable target, so it is dropped.
  always_comb begin
    pred_valid  = hit_any && !(hit_kind == KIND_RET && ras_empty);
    pred_taken  = 1'b0;
    pred_target = '0;
    pred_index  = '0;
    pred_kind   = '0;
    if (pred_valid) begin
      pred_taken  = (hit_kind == KIND_COND) ? cnt_mem[hit_idx][CNT_W-1] : 1'b1;
      pred_target = {(hit_kind == KIND_RET) ? ras_mem[ras_ptr] : target_mem[hit_idx], 2'b00};
      pred_index  = hit_idx;
      pred_kind   = hit_kind;
    end
  end

  always_comb begin
    do_delete   = !flush_all && upd_en && upd_delete;
    do_alloc    = !flush_all && upd_en && !upd_delete && !upd_hit && upd_taken;
    do_retarget = !flush_all && upd_en && !upd_delete && upd_hit && upd_tgt_err;
    do_count    = !flush_all && upd_en && !upd_delete && upd_hit && !upd_tgt_err;
    victim      = inv_any ? inv_idx : (zero_any ? zero_idx : lfsr[IDX_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid       <= '0;
      fetch_en_q  <= 1'b0;
      fetch_tag_q <= '0;
    end else begin
      fetch_en_q  <= fetch_en;
      fetch_tag_q <= fetch_pc[31:2];
      if (flush_all)      valid            <= '0;
      else if (do_delete) valid[upd_index] <= 1'b0;
      else if (do_alloc)  valid[victim]    <= 1'b1;
    end
  end

  // Entry payload has no reset; the valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (do_alloc) begin
        tag_mem[victim]    <= upd_pc[31:2];
        target_mem[victim] <= upd_target[31:2];
        kind_mem[victim]   <= kind_e'(upd_kind);
        cnt_mem[victim]    <= CNT_INIT;
      end else if (do_retarget) begin
        target_mem[upd_index] <= upd_target[31:2];
        kind_mem[upd_index]   <= kind_e'(upd_kind);
        cnt_mem[upd_index]    <= CNT_INIT;
      end else if (do_count) begin
        if (upd_taken && cnt_mem[upd_index] != '1)
          cnt_mem[upd_index] <= cnt_mem[upd_index] + 1'b1;
        else if (!upd_taken && cnt_mem[upd_index] != '0)
          cnt_mem[upd_index] <= cnt_mem[upd_index] - 1'b1;
      end
    end
  end

  assign restore_ckpt = ras_ckpt_t'(ras_restore_ckpt);
  assign ras_ckpt     = {ras_ptr, ras_cnt};

  // Push+pop on a live stack swaps the top in place; on an empty stack it is a push.
  always_comb begin
    ras_ptr_nxt = ras_ptr;
    ras_cnt_nxt = ras_cnt;
    ras_we      = 1'b0;
    ras_wptr    = ras_ptr + 1'b1;
    if (ras_restore_en) begin
      ras_ptr_nxt = restore_ckpt.ptr;
      ras_cnt_nxt = restore_ckpt.count;
    end else if (ras_push && ras_pop && !ras_empty) begin
      ras_we   = 1'b1;
      ras_wptr = ras_ptr;
    end else if (ras_push) begin
      ras_we      = 1'b1;
      ras_ptr_nxt = ras_ptr + 1'b1;
      if (ras_cnt != RAS_FULL) ras_cnt_nxt = ras_cnt + 1'b1;
    end else if (ras_pop && !ras_empty) begin
      ras_ptr_nxt = ras_ptr - 1'b1;
      ras_cnt_nxt = ras_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      lfsr    <= 8'hA5;
    end else begin
      ras_ptr <= ras_ptr_nxt;
      ras_cnt <= ras_cnt_nxt;
      lfsr    <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && ras_we) ras_mem[ras_wptr] <= ras_push_pc[31:2] + 30'd1;
  end

endmodule

// File: tb/tb_bpu_btb_ras.sv
// Directed scoreboard bench for bpu_btb_ras: BTB allocate/train/replace and RAS
// push/pop/overflow/checkpoint behaviour.
module tb_bpu_btb_ras;
  import bpu_pkg::*;

  localparam int IDX_W = 5;
  localparam int RP_W  = 3;

  logic              clk, reset;
  logic              fetch_en;
  logic [31:0]       fetch_pc;
  logic              pred_valid, pred_taken;
  logic [31:0]       pred_target;
  logic [IDX_W-1:0]  pred_index;
  logic [1:0]        pred_kind;
  logic              upd_en, upd_hit, upd_taken, upd_tgt_err, upd_delete;
  logic [31:0]       upd_pc, upd_target;
  logic [IDX_W-1:0]  upd_index;
  logic [1:0]        upd_kind;
  logic              ras_push, ras_pop, ras_restore_en, flush_all;
  logic [31:0]       ras_push_pc;
  logic [2*RP_W:0]   ras_ckpt, ras_restore_ckpt, saved_ckpt;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic             valid;
    logic             taken;
    logic [31:0]      target;
    logic [IDX_W-1:0] index;
    logic [1:0]       kind;
  } pred_t;

  pred_t exp_q[$];
  logic [7:0] lfsr_m;
  logic [IDX_W-1:0] v, ti, ci;

  bpu_btb_ras dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .fetch_pc(fetch_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_index(pred_index), .pred_kind(pred_kind),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_index(upd_index), .upd_hit(upd_hit),
    .upd_kind(upd_kind), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_tgt_err(upd_tgt_err), .upd_delete(upd_delete),
    .ras_push(ras_push), .ras_pop(ras_pop), .ras_push_pc(ras_push_pc),
    .ras_ckpt(ras_ckpt), .ras_restore_en(ras_restore_en),
    .ras_restore_ckpt(ras_restore_ckpt), .flush_all(flush_all)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR used to predict the random victim.
  always @(posedge clk) begin
    if (reset) lfsr_m <= 8'hA5;
    else       lfsr_m <= {1'b0, lfsr_m[7:1]} ^ (lfsr_m[0] ? 8'hB8 : 8'h00);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic pred_t mk(input logic vld, input logic tk, input logic [31:0] tg,
                               input logic [IDX_W-1:0] ix, input logic [1:0] kd);
    pred_t p;
    p.valid = vld; p.taken = tk; p.target = tg; p.index = ix; p.kind = kd;
    return p;
  endfunction

  function automatic pred_t miss();
    return mk(1'b0, 1'b0, 32'h0, '0, 2'd0);
  endfunction

  task automatic check_output(input string tag);
    pred_t e;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL %s: observed no expectation queued, expected one", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".valid"},  32'(pred_valid),  32'(e.valid));
      chk({tag, ".taken"},  32'(pred_taken),  32'(e.taken));
      chk({tag, ".target"}, pred_target,      e.target);
      chk({tag, ".index"},  32'(pred_index),  32'(e.index));
      chk({tag, ".kind"},   32'(pred_kind),   32'(e.kind));
    end
  endtask

  task automatic fetch_check(input string tag, input logic [31:0] pc, input pred_t e);
    fetch_en = 1'b1;
    fetch_pc = pc;
    exp_q.push_back(e);
    tick();
    fetch_en = 1'b0;
    check_output(tag);
  endtask

  task automatic upd(input logic hit, input logic [IDX_W-1:0] idx, input logic [1:0] kd,
                     input logic tk, input logic [31:0] tg, input logic terr,
                     input logic del, input logic [31:0] pc);
    upd_en = 1'b1; upd_hit = hit; upd_index = idx; upd_kind = kd; upd_taken = tk;
    upd_target = tg; upd_tgt_err = terr; upd_delete = del; upd_pc = pc;
    tick();
    upd_en = 1'b0; upd_hit = 1'b0; upd_taken = 1'b0; upd_tgt_err = 1'b0; upd_delete = 1'b0;
  endtask

  task automatic alloc(input logic [31:0] pc, input logic [1:0] kd, input logic [31:0] tg);
    upd(1'b0, '0, kd, 1'b1, tg, 1'b0, 1'b0, pc);
  endtask

  task automatic train(input logic [IDX_W-1:0] idx, input logic tk);
    upd(1'b1, idx, 2'd0, tk, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic ras_op(input logic push, input logic pop, input logic [31:0] pc);
    ras_push = push; ras_pop = pop; ras_push_pc = pc;
    tick();
    ras_push = 1'b0; ras_pop = 1'b0;
  endtask

  task automatic restore(input logic [2*RP_W:0] c, input logic push, input logic [31:0] pc);
    ras_restore_en = 1'b1; ras_restore_ckpt = c; ras_push = push; ras_push_pc = pc;
    tick();
    ras_restore_en = 1'b0; ras_push = 1'b0;
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; fetch_pc = '0;
    upd_en = 1'b0; upd_pc = '0; upd_index = '0; upd_hit = 1'b0; upd_kind = '0;
    upd_taken = 1'b0; upd_target = '0; upd_tgt_err = 1'b0; upd_delete = 1'b0;
    ras_push = 1'b0; ras_pop = 1'b0; ras_push_pc = '0;
    ras_restore_en = 1'b0; ras_restore_ckpt = '0; flush_all = 1'b0;
    tick(); tick();
    chk("rst.valid",  32'(pred_valid), 32'h0);
    chk("rst.taken",  32'(pred_taken), 32'h0);
    chk("rst.target", pred_target,     32'h0);
    chk("rst.ckpt",   32'(ras_ckpt),   32'h0);
    reset = 1'b0;
    tick();

    // Allocation and counter training on entry 0
    fetch_check("cold", 32'h1000, miss());
    alloc(32'h1000, KIND_COND, 32'h2000);
    fetch_check("alloc0", 32'h1000, mk(1'b1, 1'b1, 32'h2000, 5'd0, KIND_COND));
    train(5'd0, 1'b0); train(5'd0, 1'b0); train(5'd0, 1'b0);
    fetch_check("nt3", 32'h1000, mk(1'b1, 1'b0, 32'h2000, 5'd0, KIND_COND));
    train(5'd0, 1'b0);
    fetch_check("nt4", 32'h1000, mk(1'b1, 1'b0, 32'h2000, 5'd0, KIND_COND));

    // Fill the rest; entry 0 (counter 0) becomes the victim
    for (int i = 1; i < 32; i++) alloc(32'h1000 + 32'(4 * i), KIND_COND, 32'h3000 + 32'(4 * i));
    fetch_check("fill31", 32'h107C, mk(1'b1, 1'b1, 32'h307C, 5'd31, KIND_COND));
    alloc(32'h5000, KIND_JUMP, 32'h5100);
    fetch_check("zvict", 32'h5000, mk(1'b1, 1'b1, 32'h5100, 5'd0, KIND_JUMP));
    fetch_check("zvict_old", 32'h1000, miss());

    // All counters nonzero: victim comes from the LFSR
    v = lfsr_m[IDX_W-1:0];
    alloc(32'h6000, KIND_CALL, 32'h6100);
    fetch_check("lfsr_vict", 32'h6000, mk(1'b1, 1'b1, 32'h6100, v, KIND_CALL));

    ti = (v == 5'd5) ? 5'd6 : 5'd5;
    ci = (v == 5'd9) ? 5'd10 : 5'd9;
    upd(1'b1, ti, KIND_JUMP, 1'b1, 32'h7000, 1'b1, 1'b0, 32'h1000 + 32'(ti) * 4);
    fetch_check("tgt_err", 32'h1000 + 32'(ti) * 4, mk(1'b1, 1'b1, 32'h7000, ti, KIND_JUMP));

    train(ci, 1'b1); train(ci, 1'b1); train(ci, 1'b0);
    fetch_check("sat_hi", 32'h1000 + 32'(ci) * 4, mk(1'b1, 1'b1, 32'h3000 + 32'(ci) * 4, ci, KIND_COND));
    train(ci, 1'b0);
    fetch_check("sat_dec", 32'h1000 + 32'(ci) * 4, mk(1'b1, 1'b0, 32'h3000 + 32'(ci) * 4, ci, KIND_COND));
    upd(1'b1, ci, KIND_COND, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1000 + 32'(ci) * 4);
    fetch_check("delete", 32'h1000 + 32'(ci) * 4, miss());

    flush_all = 1'b1; tick(); flush_all = 1'b0;
    fetch_check("flush", 32'h1000 + 32'(ti) * 4, miss());

    alloc(32'hA000, KIND_COND, 32'hB000);
    alloc(32'hA000, KIND_COND, 32'hC000);
    fetch_check("dup_low", 32'hA000, mk(1'b1, 1'b1, 32'hB000, 5'd0, KIND_COND));

    // Return-address stack
    alloc(32'h8000, KIND_RET, 32'h0);
    fetch_check("ret_empty", 32'h8000, miss());
    ras_op(1'b1, 1'b0, 32'h100); ras_op(1'b1, 1'b0, 32'h200); ras_op(1'b1, 1'b0, 32'h300);
    chk("ckpt3", 32'(ras_ckpt), 32'h33);
    fetch_check("ret3", 32'h8000, mk(1'b1, 1'b1, 32'h304, 5'd2, KIND_RET));
    ras_op(1'b0, 1'b1, 32'h0);
    fetch_check("ret_pop", 32'h8000, mk(1'b1, 1'b1, 32'h204, 5'd2, KIND_RET));
    ras_op(1'b1, 1'b1, 32'h700);
    chk("ckpt_swap", 32'(ras_ckpt), 32'h22);
    fetch_check("ret_swap", 32'h8000, mk(1'b1, 1'b1, 32'h704, 5'd2, KIND_RET));

    restore('0, 1'b0, 32'h0);
    chk("ckpt_zero", 32'(ras_ckpt), 32'h0);
    for (int k = 0; k < 9; k++) ras_op(1'b1, 1'b0, 32'(32'h100 * (k + 1)));
    chk("ckpt_ovf", 32'(ras_ckpt), 32'h18);
    fetch_check("ret_ovf", 32'h8000, mk(1'b1, 1'b1, 32'h904, 5'd2, KIND_RET));
    for (int k = 0; k < 7; k++) ras_op(1'b0, 1'b1, 32'h0);
    fetch_check("ret_deep", 32'h8000, mk(1'b1, 1'b1, 32'h204, 5'd2, KIND_RET));
    ras_op(1'b0, 1'b1, 32'h0);
    chk("ckpt_empty", 32'(ras_ckpt), 32'h10);
    ras_op(1'b0, 1'b1, 32'h0);
    chk("ckpt_underflow", 32'(ras_ckpt), 32'h10);
    fetch_check("ret_supp", 32'h8000, miss());

    restore('0, 1'b0, 32'h0);
    ras_op(1'b1, 1'b0, 32'h1100); ras_op(1'b1, 1'b0, 32'h1200);
    chk("ckpt_save", 32'(ras_ckpt), 32'h22);
    saved_ckpt = ras_ckpt;
    ras_op(1'b1, 1'b0, 32'h1300); ras_op(1'b1, 1'b0, 32'h1400);
    restore(saved_ckpt, 1'b0, 32'h0);
    fetch_check("ret_restore", 32'h8000, mk(1'b1, 1'b1, 32'h1204, 5'd2, KIND_RET));
    restore(saved_ckpt, 1'b1, 32'h1500);
    chk("ckpt_rst_push", 32'(ras_ckpt), 32'h22);
    fetch_check("ret_rst_push", 32'h8000, mk(1'b1, 1'b1, 32'h1204, 5'd2, KIND_RET));

    // Reset in the middle of operation
    reset = 1'b1; fetch_en = 1'b1; fetch_pc = 32'h8000;
    tick();
    chk("midrst.valid", 32'(pred_valid), 32'h0);
    chk("midrst.ckpt",  32'(ras_ckpt),   32'h0);
    reset = 1'b0; fetch_en = 1'b0;
    fetch_check("post_rst", 32'h8000, miss());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
